// File: rtl/pspin_stdout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pspin_stdout_pkg
// Purpose  : Shared constants for the PsPIN stdout collection path.
//            STDOUT_WORD_WIDTH - word width expected by the register file
//            STDOUT_DEFAULT_DEPTH - default FIFO capacity in words
//            STDOUT_EMPTY_READ - value the register file returns when the
//                                FIFO has nothing to offer
// Revision : 1.0 - initial release
// ============================================================================
package pspin_stdout_pkg;

   localparam int STDOUT_WORD_WIDTH    = 32;
   localparam int STDOUT_DEFAULT_DEPTH = 512;
   localparam logic [STDOUT_WORD_WIDTH-1:0] STDOUT_EMPTY_READ = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/pspin_stdout_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : pspin_stdout_fifo_if
// Purpose  : Bundles the producer handshake, the FWFT read port and the
//            status outputs of the stdout FIFO.
//            s_data/s_valid/s_ready  - per-cluster producer streams
//            stdout_dout/_data_valid/_rd_en - FWFT consumer port
//            fill_level, overflow_stall_cnt - status
//            slave  : FIFO side     master : producer/consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface pspin_stdout_fifo_if
   import pspin_stdout_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int DATA_WIDTH = STDOUT_WORD_WIDTH,
   parameter int CNT_WIDTH  = $clog2(STDOUT_DEFAULT_DEPTH) + 1
);

   logic [NUM_SRC*DATA_WIDTH-1:0] s_data;
   logic [NUM_SRC-1:0]            s_valid;
   logic [NUM_SRC-1:0]            s_ready;
   logic [DATA_WIDTH-1:0]         stdout_dout;
   logic                          stdout_data_valid;
   logic                          stdout_rd_en;
   logic [CNT_WIDTH-1:0]          fill_level;
   logic [31:0]                   overflow_stall_cnt;

   modport slave (
      input  s_data, s_valid, stdout_rd_en,
      output s_ready, stdout_dout, stdout_data_valid, fill_level, overflow_stall_cnt
   );

   modport master (
      output s_data, s_valid, stdout_rd_en,
      input  s_ready, stdout_dout, stdout_data_valid, fill_level, overflow_stall_cnt
   );

endinterface
`default_nettype wire

// File: rtl/pspin_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : pspin_rr_arb
// Purpose  : Round-robin arbiter. Grants the first requester at or above the
//            rotating pointer (wrapping), and moves the pointer one past the
//            granted source when the grant is actually used.
//            clk, rst  - clock, synchronous active-high reset
//            req       - request vector
//            advance   - grant consumed this cycle
//            grant     - one-hot grant (all zero when no request)
//            grant_idx - index of the granted source
// Revision : 1.0 - initial release
// ============================================================================
module pspin_rr_arb #(
   parameter int NUM_SRC   = 2,
   parameter int IDX_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic [NUM_SRC-1:0]   req,
   input  wire logic                 advance,
   output logic      [NUM_SRC-1:0]   grant,
   output logic      [IDX_WIDTH-1:0] grant_idx
);

   logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic                 found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         automatic int cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IDX_WIDTH'(cand);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (advance) begin
         if (int'(grant_idx) == NUM_SRC - 1) rr_ptr_d = '0;
         else                                rr_ptr_d = grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end

endmodule
`default_nettype wire

// File: rtl/pspin_stdout_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pspin_stdout_fifo
// Purpose  : Collects stdout words from NUM_SRC cluster streams (round-robin)
//            into a circular FIFO with a first-word-fall-through read port.
//            Capacity is DEPTH words: up to DEPTH-1 in RAM plus the output
//            register.
//            clk, rst - clock, synchronous active-high reset
//            bus      - slave side of pspin_stdout_fifo_if
// Revision : 1.0 - initial release
// ============================================================================
module pspin_stdout_fifo
   import pspin_stdout_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int DATA_WIDTH = STDOUT_WORD_WIDTH,
   parameter int DEPTH      = STDOUT_DEFAULT_DEPTH,
   parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
   input wire logic           clk,
   input wire logic           rst,
   pspin_stdout_fifo_if.slave bus
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int IDX_WIDTH  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(DEPTH);

   // RAM is addressed by the low pointer bits; occupancy never exceeds
   // DEPTH-1, so a live read slot never collides with the write slot.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  fill_q, fill_d;
   logic [31:0]           stall_q, stall_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d;

   logic [CNT_WIDTH-1:0]  ram_cnt;
   logic                  ram_empty;
   logic                  full;
   logic [NUM_SRC-1:0]    grant;
   logic [IDX_WIDTH-1:0]  grant_idx;
   logic [NUM_SRC-1:0]    s_ready;
   logic                  push;
   logic                  pop;
   logic                  load_out;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] push_data;

   pspin_rr_arb #(
      .NUM_SRC   (NUM_SRC),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (bus.s_valid),
      .advance   (push),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      ram_cnt   = wr_ptr_q - rd_ptr_q;
      ram_empty = (ram_cnt == '0);
      full      = (fill_q == FULL_LEVEL);
      // Readiness comes only from registered state; a pop in the same cycle
      // does not open a slot until the next cycle.
      s_ready   = (rst || full) ? '0 : grant;
      push      = |(bus.s_valid & s_ready);
      push_data = bus.s_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      pop       = bus.stdout_rd_en & valid_q;
      load_out  = !valid_q || pop;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      stall_d  = stall_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      ram_we   = 1'b0;

      // Output register refills from RAM first; only with the RAM empty may
      // the incoming word bypass straight into it, preserving order.
      if (load_out) begin
         if (!ram_empty) begin
            dout_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
         end else if (push) begin
            dout_d  = push_data;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end

      ram_we = push && !(load_out && ram_empty);
      if (ram_we) wr_ptr_d = wr_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase

      if ((|bus.s_valid) && full && (stall_q != 32'hFFFF_FFFF))
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         stall_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         stall_q  <= stall_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= push_data;
   end

   assign bus.s_ready            = s_ready;
   assign bus.stdout_dout        = dout_q;
   assign bus.stdout_data_valid  = valid_q;
   assign bus.fill_level         = fill_q;
   assign bus.overflow_stall_cnt = stall_q;

endmodule
`default_nettype wire
